// File: rtl/debounce_multi.sv
// N-channel counter-based debouncer: clean level plus one-cycle press/released pulses.
// Optional macro DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer per channel.
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] bt,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] released,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] p;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] cnt_nz;

    assign p = bt ^ {CHANNELS{ACTIVE_LOW}};

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] sync1_reg;
    logic [CHANNELS-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= p;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg;
`else
    assign s = p;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic             out_reg;
            logic             press_reg;
            logic             rel_reg;

            // Any sample matching the current level restarts qualification.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    out_reg   <= 1'b0;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    if (s[gi] == out_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        cnt_reg   <= '0;
                        out_reg   <= ~out_reg;
                        press_reg <= ~out_reg;
                        rel_reg   <= out_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign out[gi]      = out_reg;
            assign press[gi]    = press_reg;
            assign released[gi] = rel_reg;
            assign cnt_nz[gi]   = |cnt_reg;
        end
    endgenerate

    assign busy = |cnt_nz;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with STABLE_CYCLES=4; one active-high and one active-low instance.
module tb_debounce_multi;

    localparam int CH = 4;
    localparam int SC = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int Q = LAT + SC;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] bt;
    logic [CH-1:0] out;
    logic [CH-1:0] press;
    logic [CH-1:0] released;
    logic          busy;
    logic [CH-1:0] bt_al;
    logic [CH-1:0] out_al;
    logic [CH-1:0] press_al;
    logic [CH-1:0] released_al;
    logic          busy_al;

    int n_cmp = 0;
    int n_err = 0;
    int presses;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .bt(bt), .out(out),
        .press(press), .released(released), .busy(busy)
    );

    debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .bt(bt_al), .out(out_al),
        .press(press_al), .released(released_al), .busy(busy_al)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        $display("check %s obs=%0h exp=%0h", tag, got, exp);
        assert (got === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("%s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bt    = '0;
        bt_al = '1;
        tick();
        tick();
        check("rst out", 32'(out), 32'h0);
        check("rst press", 32'(press), 32'h0);
        check("rst released", 32'(released), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst out_al", 32'(out_al), 32'h0);
        check("rst press_al", 32'(press_al), 32'h0);
        reset = 1'b0;

        // Basic press on channel 0
        bt[0] = 1'b1;
        for (int k = 1; k <= Q + 3; k++) begin
            tick();
            check($sformatf("t1 out0 k%0d", k), 32'(out[0]), 32'(k >= Q));
            check($sformatf("t1 press0 k%0d", k), 32'(press[0]), 32'(k == Q));
            check($sformatf("t1 busy k%0d", k), 32'(busy), 32'(k > LAT && k < Q));
        end

        // Bounce on channel 1: high 3, low 1, high held
        presses = 0;
        for (int k = 1; k <= 8 + LAT + 3; k++) begin
            bt[1] = (k != 4);
            tick();
            if (press[1]) presses++;
            check($sformatf("t2 out1 k%0d", k), 32'(out[1]), 32'(k >= 8 + LAT));
            check($sformatf("t2 rel1 k%0d", k), 32'(released[1]), 32'h0);
        end
        check("t2 press count", 32'(presses), 32'd1);

        // Release on channel 2
        bt[2] = 1'b1;
        for (int k = 1; k <= Q + 1; k++) tick();
        check("t3 out2 set", 32'(out[2]), 32'h1);
        bt[2] = 1'b0;
        for (int k = 1; k <= Q + 2; k++) begin
            tick();
            check($sformatf("t3 out2 k%0d", k), 32'(out[2]), 32'(k < Q));
            check($sformatf("t3 rel2 k%0d", k), 32'(released[2]), 32'(k == Q));
            check($sformatf("t3 press2 k%0d", k), 32'(press[2]), 32'h0);
        end

        // Active-low instance, channel 3 pressed low
        bt_al[3] = 1'b0;
        for (int k = 1; k <= Q + 2; k++) begin
            tick();
            check($sformatf("t4 out_al k%0d", k), 32'(out_al), 32'(k >= Q ? 4'b1000 : 4'b0000));
            check($sformatf("t4 press_al k%0d", k), 32'(press_al), 32'(k == Q ? 4'b1000 : 4'b0000));
        end

        // Reset mid-count on channel 0: release first, then press and interrupt
        bt[0] = 1'b0;
        for (int k = 1; k <= Q + 1; k++) tick();
        check("t5 out0 cleared", 32'(out[0]), 32'h0);
        bt[0] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) tick();
        check("t5 busy midcount", 32'(busy), 32'h1);
        check("t5 out0 midcount", 32'(out[0]), 32'h0);
        reset = 1'b1;
        tick();
        check("t5 out in reset", 32'(out), 32'h0);
        check("t5 press in reset", 32'(press), 32'h0);
        check("t5 busy in reset", 32'(busy), 32'h0);
        reset = 1'b0;
        presses = 0;
        for (int k = 1; k <= Q + 3; k++) begin
            tick();
            if (press[0]) presses++;
            check($sformatf("t5 out0 k%0d", k), 32'(out[0]), 32'(k >= Q));
            check($sformatf("t5 press01 k%0d", k), 32'(press[1:0]), 32'(k == Q ? 2'b11 : 2'b00));
        end
        check("t5 press count", 32'(presses), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised N-channel, counter-based debouncer for push-buttons and switches. Successor to the fixed 3-stage toggle-flop debouncer: stable time is configurable, both press and release are filtered, and a bounce restarts the count. Provides a clean level plus one-cycle press and release pulses per channel. Sits between board input pins and the control FSMs, e.g. single-step and mode buttons.

Parameters:
CHANNELS, 4, number of independent input channels (>=1).
STABLE_CYCLES, 16, consecutive identical samples required before the filtered level flips (>=2).
ACTIVE_LOW, 0, 1 = raw inputs are pressed-low; inverted at entry so all outputs are active-high "pressed".
CNT_W, $clog2(STABLE_CYCLES), per-channel counter width (derived; not to be overridden).

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  synchronous, active-high reset.
bt  in  CHANNELS  raw button/switch inputs, asynchronous to clk.
out  out  CHANNELS  debounced level per channel (1 = pressed).
press  out  CHANNELS  one-cycle pulse when out[i] goes 0->1.
release  out  CHANNELS  one-cycle pulse when out[i] goes 1->0.
busy  out  1  OR of all channels whose counter is non-zero (filter mid-evaluation).

Behaviour:
- Single clock. One synchronous, active-high reset: sampled on the rising edge of clk and takes precedence over all other activity.
- Reset: out=0, press=0, release=0, busy=0. All counters=0. Synchronizer flops (if present) = 0 after polarity inversion.
- Entry: p[i] = bt[i] ^ ACTIVE_LOW. Sample s[i] = p[i] directly, or synchronized (see Optional Feature).
- Per channel, every edge, no reset:
  - s[i] == out[i]: counter cleared to 0. Covers bounce back to the stable level mid-count.
  - s[i] != out[i] and counter < STABLE_CYCLES-1: counter +1.
  - s[i] != out[i] and counter == STABLE_CYCLES-1: out[i] toggles, counter cleared to 0, and the matching press/release bit is asserted for that edge only.
- Filtered level therefore flips on the STABLE_CYCLES-th consecutive differing sample edge.
- Any single matching sample restarts qualification from zero.
- press/release are registered. High exactly one cycle, coincident with the cycle out[i] shows its new value.
- press[i] and release[i] are never high together.
- Counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Channels are fully independent. Simultaneous qualification on several channels gives simultaneous pulses.
- Reset asserted mid-count: counter discarded, out forced to 0, no pulse generated. After reset, an input already held pressed re-qualifies from zero and produces one press pulse.
- busy is combinational from the counters: high while any counter != 0.
- Held input: once qualified, no further pulses regardless of hold length.

Optional Feature:
Macro DEBOUNCE_SYNC_EN.
- Defined: each p[i] passes through a 2-flop synchronizer (reset to 0) before use as s[i]. Adds exactly 2 cycles of latency. Required whenever bt comes from pins.
- Undefined: s[i] = p[i] combinationally. For benches and for inputs already synchronous to clk. No added latency.
- Pulse and counter rules are identical in both builds.

Test Plan:
- STABLE_CYCLES=4, no macro: bt[0] 0->1 held before edge 1 -> out[0]=1 and press[0]=1 after edge 4; press[0]=0 after edge 5; busy=1 after edges 1-3.
- Same, macro defined -> out[0] and press[0] high after edge 6, one cycle only.
- Bounce, STABLE_CYCLES=4: bt[1] high 3 edges, low 1 edge, high 4 edges -> out[1] rises only after edge 8 (the 4th edge of the final run); exactly one press pulse.
- Release: out[2]=1, bt[2] low for 4 edges -> release[2] one cycle, out[2]=0; press[2] never high.
- ACTIVE_LOW=1: reset with bt=all 1 -> out=0, no pulses. Drive bt[3]=0 for STABLE_CYCLES edges -> out[3]=1 and press[3] pulse.
- Reset mid-count: bt[0]=1 for 2 edges, reset for 1 edge, bt[0] stays 1 -> out[0]=0 through reset, then rises exactly STABLE_CYCLES edges after reset deasserts; single press pulse.
